alarm_controller: RTL
=====================

// Module: alarm_controller
// PURPOSE
//  Sequences the alarm behaviour of the digital alarm clock: compares running time against the
//  stored alarm, drives the ring/blink outputs, and handles dismiss, snooze and ring timeout.
//  Sits between the time/alarm counters and the LED/buzzer outputs, fed by debounced button pulses.
// PARAMETERS
//  RING_TIMEOUT_S  60   ticks of continuous ringing before auto-stop (1..255)
//  SNOOZE_S        300  ticks of snooze before re-ring (1..511)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-low
//  tick_1hz     in   1  one-cycle pulse per second, synchronous to clk
//  adjust       in   1  1 = user is in time/alarm adjust mode
//  alarm_en     in   1  1 = alarm armed
//  time_h       in   5  current hours 0..23
//  time_m       in   6  current minutes 0..59
//  time_s       in   6  current seconds 0..59
//  alarm_h      in   5  alarm hours 0..23
//  alarm_m      in   6  alarm minutes 0..59
//  dismiss      in   1  one-cycle pulse (center button)
//  snooze_req   in   1  one-cycle pulse (up or down button)
//  ringing      out  1  1 while in RING
//  blink        out  1  alarm LED; toggles each tick in RING, else 0
//  snoozing     out  1  1 while in SNOOZE
//  snooze_left  out  9  remaining snooze ticks; 0 outside SNOOZE
//  missed       out  1  sticky: ring timed out without dismiss
// BEHAVIOUR
//  - Reset (rst=0): state IDLE; ringing, blink, snoozing, snooze_left, missed, match_d all 0.
//  - match = alarm_en & ~adjust & time_h==alarm_h & time_m==alarm_m & time_s==0.
//    trigger = match & ~match_d (match_d is match registered). One trigger per alarm minute.
//  - All outputs registered; trigger seen in cycle N -> ringing=1, blink=1 in cycle N+1.
//  - States: IDLE, RING, SNOOZE (2-bit encoding, illegal codes -> IDLE).
//    IDLE  : trigger -> RING (ring_cnt=0, blink=1).
//    RING  : tick -> ring_cnt+1, blink toggles; ring_cnt reaching RING_TIMEOUT_S -> IDLE, missed=1.
//            dismiss -> IDLE. snooze_req -> SNOOZE, snooze_left=SNOOZE_S.
//    SNOOZE: tick -> snooze_left-1; snooze_left 1->0 on tick -> RING (ring_cnt=0, blink=1).
//            dismiss -> IDLE. snooze_req ignored (no re-arm). trigger -> RING, snooze_left=0.
//  - Same-cycle priority: (~alarm_en | adjust) > dismiss > snooze_req > tick > trigger.
//    ~alarm_en or adjust in any state forces IDLE next cycle; missed unaffected.
//  - missed: set on timeout; cleared by dismiss pulse in any state or by a new trigger.
//  - snooze_req in IDLE and dismiss in IDLE (other than clearing missed) have no effect.
//  - Reset mid-ring/snooze: immediate return to reset values; no memory of prior alarm.
//    Reset released during an active match second re-triggers (match_d=0) -- intended.
//  - Counters never wrap: ring_cnt saturates at RING_TIMEOUT_S, snooze_left stops at 0.
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: SNOOZE state, snooze_req and snooze_left behave as above.
//  ALARM_SNOOZE_EN undefined: SNOOZE state removed; snooze_req ignored; snoozing and
//   snooze_left tied 0; RING exits only via dismiss, timeout, ~alarm_en or adjust.
// TESTING
//  1 alarm 07:30, alarm_en=1, time steps 07:29:59->07:30:00 -> ringing=1 next cycle,
//    blink toggles each tick, stays low after 07:30:01 only if dismissed.
//  2 ringing, RING_TIMEOUT_S=4, no buttons -> after 4th tick ringing=0, missed=1;
//    dismiss pulse -> missed=0.
//  3 ringing, snooze_req (SNOOZE_S=3, ALARM_SNOOZE_EN) -> snoozing=1, snooze_left=3,2,1,0
//    on ticks, then ringing=1, snoozing=0, blink=1.
//  4 dismiss and snooze_req in same cycle during RING -> IDLE, snoozing stays 0.
//  5 ringing, adjust=1 -> ringing=0 next cycle; adjust=1 at 07:30:00 -> no trigger.
//  6 rst=0 asserted asynchronously mid-SNOOZE -> all outputs 0 without waiting for clk edge;
//    build without ALARM_SNOOZE_EN: snooze_req in RING -> still ringing, snoozing=0.

Source files
------------

// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its surroundings (time/alarm counters, buttons, LED/buzzer).
// Suffixes are from the controller's point of view: _i feeds the controller, _o comes out of it.
interface alarm_controller_if;
    logic       tick_1hz_i;
    logic       adjust_i;
    logic       alarm_en_i;
    logic [4:0] time_h_i;
    logic [5:0] time_m_i;
    logic [5:0] time_s_i;
    logic [4:0] alarm_h_i;
    logic [5:0] alarm_m_i;
    logic       dismiss_i;
    logic       snooze_req_i;
    logic       ringing_o;
    logic       blink_o;
    logic       snoozing_o;
    logic [8:0] snooze_left_o;
    logic       missed_o;

    modport master (
        output tick_1hz_i, adjust_i, alarm_en_i, time_h_i, time_m_i, time_s_i,
               alarm_h_i, alarm_m_i, dismiss_i, snooze_req_i,
        input  ringing_o, blink_o, snoozing_o, snooze_left_o, missed_o
    );

    modport slave (
        input  tick_1hz_i, adjust_i, alarm_en_i, time_h_i, time_m_i, time_s_i,
               alarm_h_i, alarm_m_i, dismiss_i, snooze_req_i,
        output ringing_o, blink_o, snoozing_o, snooze_left_o, missed_o
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: detects the alarm minute, rings with a blinking LED, handles dismiss, snooze and timeout.
// Snooze support (SNOOZE state, snooze_req, snooze_left) is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_controller #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    alarm_controller_if.slave  bus
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01
    } state_e;
`endif

    localparam logic [7:0] RING_MAX    = 8'(RING_TIMEOUT_S);
    localparam logic [8:0] SNOOZE_INIT = 9'(SNOOZE_S);

    state_e     state_q, state_d;
    logic [7:0] ringCnt_q, ringCnt_d;
    logic       blink_q, blink_d;
    logic       missed_q, missed_d;
    logic       match_q, match_d;
    logic       forceIdle;
    logic       trigger;
`ifdef ALARM_SNOOZE_EN
    logic [8:0] snoozeLeft_q, snoozeLeft_d;
`else
    logic       unusedSnooze;
    assign unusedSnooze = &{1'b0, bus.snooze_req_i, SNOOZE_INIT};
`endif

    // The match is only honoured on its rising edge, so one alarm minute yields a single trigger.
    assign forceIdle = ~bus.alarm_en_i | bus.adjust_i;
    assign match_d   = bus.alarm_en_i & ~bus.adjust_i
                     & (bus.time_h_i == bus.alarm_h_i)
                     & (bus.time_m_i == bus.alarm_m_i)
                     & (bus.time_s_i == 6'd0);
    assign trigger   = match_d & ~match_q;

    always_comb begin
        state_d      = state_q;
        ringCnt_d    = ringCnt_q;
        blink_d      = blink_q;
        missed_d     = missed_q;
`ifdef ALARM_SNOOZE_EN
        snoozeLeft_d = snoozeLeft_q;
`endif
        if (bus.dismiss_i)
            missed_d = 1'b0;

        if (forceIdle) begin
            state_d      = IDLE;
            ringCnt_d    = 8'd0;
            blink_d      = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozeLeft_d = 9'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.dismiss_i && trigger) begin
                        state_d   = RING;
                        ringCnt_d = 8'd0;
                        blink_d   = 1'b1;
                        missed_d  = 1'b0;
                    end
                end
                RING: begin
                    if (bus.dismiss_i) begin
                        state_d   = IDLE;
                        ringCnt_d = 8'd0;
                        blink_d   = 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.snooze_req_i) begin
                        state_d      = SNOOZE;
                        ringCnt_d    = 8'd0;
                        blink_d      = 1'b0;
                        snoozeLeft_d = SNOOZE_INIT;
`endif
                    end else if (bus.tick_1hz_i) begin
                        // Timeout leaves ringCnt saturated; the next ring start clears it.
                        if (ringCnt_q >= RING_MAX - 8'd1) begin
                            state_d   = IDLE;
                            ringCnt_d = RING_MAX;
                            blink_d   = 1'b0;
                            missed_d  = 1'b1;
                        end else begin
                            ringCnt_d = ringCnt_q + 8'd1;
                            blink_d   = ~blink_q;
                        end
                    end else if (trigger) begin
                        ringCnt_d = 8'd0;
                        blink_d   = 1'b1;
                        missed_d  = 1'b0;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (bus.dismiss_i) begin
                        state_d      = IDLE;
                        snoozeLeft_d = 9'd0;
                    end else if (bus.tick_1hz_i) begin
                        if (snoozeLeft_q <= 9'd1) begin
                            state_d      = RING;
                            ringCnt_d    = 8'd0;
                            blink_d      = 1'b1;
                            snoozeLeft_d = 9'd0;
                        end else begin
                            snoozeLeft_d = snoozeLeft_q - 9'd1;
                        end
                    end else if (trigger) begin
                        state_d      = RING;
                        ringCnt_d    = 8'd0;
                        blink_d      = 1'b1;
                        missed_d     = 1'b0;
                        snoozeLeft_d = 9'd0;
                    end
                end
`endif
                default: begin
                    state_d   = IDLE;
                    ringCnt_d = 8'd0;
                    blink_d   = 1'b0;
`ifdef ALARM_SNOOZE_EN
                    snoozeLeft_d = 9'd0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ringCnt_q <= 8'd0;
            blink_q   <= 1'b0;
            missed_q  <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ringCnt_q <= ringCnt_d;
            blink_q   <= blink_d;
            missed_q  <= missed_d;
            match_q   <= match_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            snoozeLeft_q <= 9'd0;
        else
            snoozeLeft_q <= snoozeLeft_d;
    end

    assign bus.snoozing_o    = (state_q == SNOOZE);
    assign bus.snooze_left_o = snoozeLeft_q;
`else
    assign bus.snoozing_o    = 1'b0;
    assign bus.snooze_left_o = 9'd0;
`endif

    assign bus.ringing_o = (state_q == RING);
    assign bus.blink_o   = blink_q;
    assign bus.missed_o  = missed_q;

endmodule
